rv_alu_mdu: RTL and testbench
=============================

# rv_alu_mdu

Parametrised, handshaked successor to the single-cycle execute-stage ALU: XLEN-wide integer ALU with registered output plus an iterative RV32M/RV64M multiply/divide unit. Sits in the execute stage between operand forwarding and writeback. Base ops complete in one cycle; M ops take a fixed XLEN+2 cycles. Valid/ready handshakes on both sides allow pipeline stalls and flushes.

## Interface
- XLEN, 32: datapath width; power of two, 8..64.
- SHW, $clog2(XLEN): shift-amount width, derived, do not override.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill: abandons in-flight op, drops out_valid.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- op_in  in  5  operation code, see Operation.
- rs1, rs2  in  XLEN  operands, captured on accept.
- out_valid  out  1  rd/comp_res/err valid.
- out_ready  in  1  consumer takes result.
- rd  out  XLEN  result.
- comp_res  out  1  rd[0] (compare result for SLT/SLTU).
- err  out  1  op_in was undefined; rd = 0.
- busy  out  1  M op iterating.

## Operation
- op_in[4]=0 base ops, codes unchanged: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0111, SRA 1000 (signed, sign-filling), SLT 1001 (signed), SLTU 1010. Shifts use rs2[SHW-1:0] only. Codes 0110, 1011-1111: rd=0, err=1.
- op_in[4]=1 M ops, op_in[2:0]: MUL 000 (low XLEN), MULH 001 (s×s high), MULHSU 010 (s×u high), MULHU 011 (u×u high), DIV 100, DIVU 101, REM 110, REMU 111. op_in[3] ignored.
- Arithmetic modulo 2^XLEN; signed ops use two's complement.
- M ops: capture |operands| and result sign at accept; XLEN radix-2 iterations (shift-add, restoring shift-subtract) into 2·XLEN accumulator; one FIX cycle negates if needed and selects half.
- Divide by zero: quotient = all ones, remainder = rs1. Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): quotient = rs1, remainder = 0. Remainder sign follows dividend.
- FSM: IDLE -> (accept M op) ITER -> after XLEN iterations FIX -> DONE. DONE -> IDLE when out_valid && out_ready. Base ops never leave IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready): result register is the only buffer; held result is never overwritten.
- busy = state in {ITER, FIX}.

## Timing
- Reset: state IDLE, out_valid 0, rd 0, comp_res 0, err 0, busy 0, in_ready 1 once rst deasserts (in_ready 0 while rst high).
- Accept = in_valid && in_ready at a rising edge.
- Base op: out_valid 1 after the accepting edge; back-to-back throughput 1/cycle with out_ready held high.
- M op: out_valid 1 exactly XLEN+2 edges after accept (XLEN ITER + FIX + load); fixed, independent of operand values including zero/overflow cases.
- Output held stable while out_valid && !out_ready.
- flush: next edge forces IDLE, out_valid 0, err 0; in_valid coincident with flush is not accepted; flush beats out_ready.
- rst mid-operation: immediate abandon, no result produced.
- Inputs may change freely after the accepting edge.

## Configuration
- RV_ALU_MULDIV_EN defined: M ops as above.
- Undefined: no multiplier/divider, no ITER/FIX states; any op_in[4]=1 treated as undefined (rd=0, err=1, 1-cycle latency); busy tied 0.

## Test plan
- XLEN=32, ADD 0x7FFFFFFF+1 -> rd 0x80000000, out_valid one edge after accept; 10 back-to-back ops with out_ready=1 -> 10 results in 10 consecutive cycles.
- SRA 0xF0000000 by rs2=0x24 (shamt 4) -> 0xFF000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0; op 01011 -> rd 0, err 1.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF; MUL 7×-3 -> 0xFFFFFFEB; out_valid exactly 34 edges after accept, busy high 33 cycles.
- DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; all 34-cycle latency.
- out_ready=0 for 5 cycles after result: rd stable, in_ready 0; then out_ready=1 with new in_valid -> accepted same edge.
- flush at iteration 10 of DIV -> out_valid never rises, in_ready 1 next cycle; rst pulse mid-MUL -> all outputs reset values; build without RV_ALU_MULDIV_EN -> MUL op gives err 1 in one cycle.

Source files
------------

// File: rtl/rv_alu_mdu.sv
// rv_alu_mdu: XLEN-wide execute-stage ALU with a registered, valid/ready result and an optional
// iterative RV32M/RV64M multiply/divide unit, compiled in when RV_ALU_MULDIV_EN is defined.
module rv_alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op_in,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            comp_res,
    output logic            err,
    output logic            busy
);
    logic [XLEN-1:0] alu_res;
    logic            alu_err;
    logic [SHW-1:0]  shamt;
    logic            can_take;
    logic            accept;

    assign shamt    = rs2[SHW-1:0];
    assign comp_res = rd[0];
    assign in_ready = !rst && can_take;
    assign accept   = in_valid && can_take;

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_in)
            5'b00000: alu_res = rs1 + rs2;
            5'b00001: alu_res = rs1 - rs2;
            5'b00010: alu_res = rs1 ^ rs2;
            5'b00011: alu_res = rs1 | rs2;
            5'b00100: alu_res = rs1 & rs2;
            5'b00101: alu_res = rs1 << shamt;
            5'b00111: alu_res = rs1 >> shamt;
            5'b01000: alu_res = $signed(rs1) >>> shamt;
            5'b01001: alu_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            5'b01010: alu_res = {{(XLEN-1){1'b0}}, rs1 < rs2};
            default:  alu_err = 1'b1;
        endcase
    end

`ifdef RV_ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
    state_t            state;
    logic [2*XLEN-1:0] acc, mul_step, div_step, prod;
    logic [XLEN-1:0]   opnd, op_a, op_b, half, fix_res;
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic [SHW-1:0]    cnt;
    logic [2:0]        mop;
    logic              neg, s1, s2, neg_in;

    // Iterate on magnitudes; the result sign is decided at accept and applied in FIX.
    assign s1     = rs1[XLEN-1] & (op_in[2] ? !op_in[0] : op_in[1:0] != 2'b11);
    assign s2     = rs2[XLEN-1] & (op_in[2] ? !op_in[0] : !op_in[1]);
    assign neg_in = op_in[2] ? (op_in[1] ? s1 : (s1 ^ s2) && |rs2) : s1 ^ s2;
    assign op_a   = s1 ? -rs1 : rs1;
    assign op_b   = s2 ? -rs2 : rs2;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_step = {mul_sum, acc[XLEN-1:1]};
    assign rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign diff     = rem_sh - {1'b0, opnd};
    assign div_step = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    // Products negate as a 2*XLEN value; quotient/remainder negate per half.
    assign prod    = neg ? -acc : acc;
    assign half    = mop[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    assign fix_res = mop[2] ? (neg ? -half : half)
                            : (mop[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    assign can_take = state == IDLE && (!out_valid || out_ready);
    assign busy     = state == ITER || state == FIX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rd        <= '0;
            err       <= 1'b0;
            acc       <= '0;
            opnd      <= '0;
            cnt       <= '0;
            mop       <= '0;
            neg       <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: if (accept && op_in[4]) begin
                    state <= ITER;
                    cnt   <= '0;
                    acc   <= {{XLEN{1'b0}}, op_a};
                    opnd  <= op_b;
                    mop   <= op_in[2:0];
                    neg   <= neg_in;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    rd        <= alu_res;
                    err       <= alu_err;
                end
                ITER: begin
                    acc <= mop[2] ? div_step : mul_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(XLEN-1))
                        state <= FIX;
                end
                FIX: begin
                    acc   <= {{XLEN{1'b0}}, fix_res};
                    state <= DONE;
                end
                DONE: if (!out_valid) begin
                    out_valid <= 1'b1;
                    rd        <= acc[XLEN-1:0];
                    err       <= 1'b0;
                end else if (out_ready) begin
                    state <= IDLE;
                end
            endcase
        end
    end
`else
    assign can_take = !out_valid || out_ready;
    assign busy     = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            rd        <= '0;
            err       <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            rd        <= alu_res;
            err       <= alu_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_rv_alu_mdu.sv
// tb_rv_alu_mdu: directed-vector bench for rv_alu_mdu at XLEN=32; M-op scenarios follow RV_ALU_MULDIV_EN.
module tb_rv_alu_mdu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  op_in = 5'b0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        in_ready, out_valid, comp_res, err, busy;
    logic [31:0] rd;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        e;
    } vec_t;

    vec_t vb [12] = '{
        '{5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0},
        '{5'b00001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0},
        '{5'b00010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0},
        '{5'b00011, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0},
        '{5'b00100, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0},
        '{5'b00101, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0},
        '{5'b00111, 32'hF0000000, 32'h00000004, 32'h0F000000, 1'b0},
        '{5'b01000, 32'hF0000000, 32'h00000024, 32'hFF000000, 1'b0},
        '{5'b01001, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0},
        '{5'b01010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
        '{5'b01011, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1},
        '{5'b00110, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1}
    };

    vec_t vm [12] = '{
        '{5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0},
        '{5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
        '{5'b10000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0},
        '{5'b11011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},
        '{5'b10100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0},
        '{5'b10110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0},
        '{5'b10101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0},
        '{5'b10111, 32'h00000005, 32'h00000000, 32'h00000005, 1'b0},
        '{5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0},
        '{5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0},
        '{5'b10100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b0},
        '{5'b10110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b0}
    };

    rv_alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op_in(op_in), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
        .rd(rd), .comp_res(comp_res), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, err, busy, comp_res} !== 5'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b err=%b busy=%b comp_res=%b rd=%h, need all zero",
                     in_ready, out_valid, err, busy, comp_res, rd);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b need 1", in_ready);
        end
    endtask

    task automatic test_base();
        foreach (vb[i]) begin
            @(negedge clk);
            op_in = vb[i].op; rs1 = vb[i].a; rs2 = vb[i].b; in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0; rs1 = 32'hDEADBEEF;
            checks++;
            if ({out_valid, err, comp_res} !== {1'b1, vb[i].e, vb[i].r[0]} || rd !== vb[i].r) begin
                errors++;
                $display("FAIL base_op%0d: out_valid=%b err=%b comp_res=%b rd=%h, need 1 %b %b %h",
                         i, out_valid, err, comp_res, rd, vb[i].e, vb[i].r[0], vb[i].r);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL base_consume%0d: out_valid=%b need 0", i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op_in = 5'b00000; rs1 = 32'(i); rs2 = 32'd100; in_valid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || rd !== 32'(i + 100)) begin
                errors++;
                $display("FAIL b2b%0d: out_valid=%b rd=%h, need 1 %h", i, out_valid, rd, 32'(i + 100));
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: out_valid=%b need 0", out_valid);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        op_in = 5'b00000; rs1 = 32'h11; rs2 = 32'h22; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        op_in = 5'b00011; rs1 = 32'hA0; rs2 = 32'h0B;
        checks++;
        if (out_valid !== 1'b1 || rd !== 32'h33) begin
            errors++;
            $display("FAIL stall_first: out_valid=%b rd=%h, need 1 00000033", out_valid, rd);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || rd !== 32'h33) begin
                errors++;
                $display("FAIL stall_hold%0d: out_valid=%b in_ready=%b rd=%h, need 1 0 00000033",
                         k, out_valid, in_ready, rd);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: in_ready=%b need 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || rd !== 32'hAB) begin
            errors++;
            $display("FAIL stall_next: out_valid=%b rd=%h, need 1 000000ab", out_valid, rd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush_base();
        @(negedge clk);
        op_in = 5'b01111; rs1 = 32'h1; rs2 = 32'h2; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, err} !== 2'b11 || rd !== 32'h0) begin
            errors++;
            $display("FAIL undef_op: out_valid=%b err=%b rd=%h, need 1 1 00000000", out_valid, err, rd);
        end
        @(negedge clk);
        out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; op_in = 5'b00000; rs1 = 32'h5; rs2 = 32'h5;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, err} !== 2'b00) begin
            errors++;
            $display("FAIL flush_kill: out_valid=%b err=%b, need 0 0", out_valid, err);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_no_accept: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
    endtask

`ifdef RV_ALU_MULDIV_EN
    task automatic test_m_ops();
        int lat, busy_n;
        foreach (vm[i]) begin
            @(negedge clk);
            op_in = vm[i].op; rs1 = vm[i].a; rs2 = vm[i].b; in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0; op_in = 5'b00000; rs1 = 32'h12345678; rs2 = 32'h9ABCDEF0;
            busy_n = int'(busy);
            lat = 0;
            for (int k = 1; k <= 40 && lat == 0; k++) begin
                @(posedge clk);
                #1;
                if (out_valid) lat = k;
                else busy_n += int'(busy);
            end
            checks++;
            if (lat != 34 || busy_n != 33) begin
                errors++;
                $display("FAIL m_timing%0d: latency=%0d busy_cycles=%0d, need 34 33", i, lat, busy_n);
            end
            checks++;
            if (rd !== vm[i].r || err !== 1'b0) begin
                errors++;
                $display("FAIL m_result%0d: rd=%h err=%b, need %h 0", i, rd, err, vm[i].r);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, busy} !== 3'b010) begin
                errors++;
                $display("FAIL m_release%0d: out_valid=%b in_ready=%b busy=%b, need 0 1 0",
                         i, out_valid, in_ready, busy);
            end
        end
    endtask

    task automatic test_m_flush();
        logic seen;
        @(negedge clk);
        op_in = 5'b10100; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b010) begin
            errors++;
            $display("FAIL m_flush: busy=%b in_ready=%b out_valid=%b, need 0 1 0", busy, in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL m_flush_silent: out_valid rose=%b need 0", seen);
        end
    endtask
`else
    task automatic test_no_m();
        logic [4:0] mops [2] = '{5'b10000, 5'b10100};
        foreach (mops[i]) begin
            @(negedge clk);
            op_in = mops[i]; rs1 = 32'd7; rs2 = 32'd3; in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checks++;
            if ({out_valid, err, busy} !== 3'b110 || rd !== 32'h0) begin
                errors++;
                $display("FAIL no_m%0d: out_valid=%b err=%b busy=%b rd=%h, need 1 1 0 00000000",
                         i, out_valid, err, busy, rd);
            end
            @(posedge clk);
            #1;
        end
    endtask
`endif

    task automatic test_rst_mid();
        logic seen;
        @(negedge clk);
        op_in = 5'b00000; rs1 = 32'h1; rs2 = 32'h2; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef RV_ALU_MULDIV_EN
        @(negedge clk);
        op_in = 5'b10000; rs1 = 32'd6; rs2 = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, err, busy, comp_res} !== 5'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: in_ready=%b out_valid=%b err=%b busy=%b comp_res=%b rd=%h, need all zero",
                     in_ready, out_valid, err, busy, comp_res, rd);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        checks++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_after: out_valid rose=%b in_ready=%b, need 0 1", seen, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_base();
        test_back_to_back();
        test_stall();
        test_flush_base();
`ifdef RV_ALU_MULDIV_EN
        test_m_ops();
        test_m_flush();
`else
        test_no_m();
`endif
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
